// File: rtl/alarm_unit.sv
// Alarm unit: stores an alarm time, matches it against the main clock and rings/snoozes.
// Optional snooze support is compiled in with `define ALARM_SNOOZE_EN.
module alarm_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  input  logic [5:0] cur_seconds,
  input  logic       alarm_en,
  input  logic       alarm_set,
  input  logic       key_next,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic       key_stop,
  input  logic       key_snooze,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes,
  output logic       edit_field,
  output logic       ringing,
  output logic       snoozing,
  output logic       play_sound
);
  typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_e;

  state_e     state_q, state_d;
  logic [5:0] ring_q, ring_d;
  logic [4:0] hours_q, hours_d;
  logic [5:0] mins_q, mins_d;
  logic       field_q, field_d;
  logic       play_q, play_d;
  logic       match;
  logic       inc_only, dec_only;

`ifdef ALARM_SNOOZE_EN
  logic [8:0] snz_q, snz_d;
`else
  logic       unused_snooze;
  assign unused_snooze = key_snooze;
`endif

  assign match = tick_1hz && !alarm_set && (cur_hours == hours_q) &&
                 (cur_minutes == mins_q) && (cur_seconds == 6'd0);

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
`ifdef ALARM_SNOOZE_EN
    snz_d   = snz_q;
`endif
    if (!alarm_en) begin
      state_d = IDLE;
    end else if (alarm_set) begin
      // Editing pulls an active alarm back to armed; otherwise the state holds.
      if (state_q == RINGING || state_q == SNOOZE) state_d = ARMED;
    end else begin
      case (state_q)
        IDLE: state_d = ARMED;
        ARMED: begin
          if (match) begin
            state_d = RINGING;
            ring_d  = 6'd0;
          end
        end
        RINGING: begin
          if (key_stop) begin
            state_d = ARMED;
`ifdef ALARM_SNOOZE_EN
          end else if (key_snooze) begin
            state_d = SNOOZE;
            snz_d   = 9'd0;
`endif
          end else if (tick_1hz) begin
            if (ring_q == 6'd59) state_d = ARMED;
            else                 ring_d  = ring_q + 6'd1;
          end
        end
        SNOOZE: begin
`ifdef ALARM_SNOOZE_EN
          if (key_stop) begin
            state_d = ARMED;
          end else if (tick_1hz) begin
            if (snz_q == 9'd299) begin
              state_d = RINGING;
              ring_d  = 6'd0;
            end else begin
              snz_d = snz_q + 9'd1;
            end
          end
`else
          state_d = ARMED;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
    play_d = (state_d == RINGING) && !ring_d[0];
  end

  // Field adjustment uses the field selected before any key_next this cycle.
  assign inc_only = key_inc && !key_dec;
  assign dec_only = key_dec && !key_inc;

  always_comb begin
    hours_d = hours_q;
    mins_d  = mins_q;
    field_d = field_q;
    if (alarm_set) begin
      if (!field_q) begin
        if (inc_only)      hours_d = (hours_q == 5'd23) ? 5'd0  : hours_q + 5'd1;
        else if (dec_only) hours_d = (hours_q == 5'd0)  ? 5'd23 : hours_q - 5'd1;
      end else begin
        if (inc_only)      mins_d = (mins_q == 6'd59) ? 6'd0  : mins_q + 6'd1;
        else if (dec_only) mins_d = (mins_q == 6'd0)  ? 6'd59 : mins_q - 6'd1;
      end
      if (key_next) field_d = !field_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ring_q  <= 6'd0;
      hours_q <= 5'd7;
      mins_q  <= 6'd0;
      field_q <= 1'b0;
      play_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
      hours_q <= hours_d;
      mins_q  <= mins_d;
      field_q <= field_d;
      play_q  <= play_d;
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) snz_q <= 9'd0;
    else     snz_q <= snz_d;
  end
  assign snoozing = (state_q == SNOOZE);
`else
  assign snoozing = 1'b0;
`endif

  assign ringing       = (state_q == RINGING);
  assign play_sound    = play_q;
  assign alarm_hours   = hours_q;
  assign alarm_minutes = mins_q;
  assign edit_field    = field_q;
endmodule

// File: doc/alarm_unit.md
ALARM_UNIT -- requirements
Module: alarm_unit

Interface
REQ-001 SHALL have port: clk  in  1  system clock, 50 MHz; one clock domain, all logic on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: tick_1hz  in  1  one-clk-wide pulse, once per time-of-day second.
REQ-004 SHALL have ports: cur_hours in 5 (0-23), cur_minutes in 6 (0-59), cur_seconds in 6 (0-59)  current main-clock time, stable around tick_1hz.
REQ-005 SHALL have port: alarm_en  in  1  level; 1 = alarm armed.
REQ-006 SHALL have port: alarm_set  in  1  level; 1 = alarm-time edit mode.
REQ-007 SHALL have ports: key_next, key_inc, key_dec, key_stop, key_snooze  in  1 each  debounced one-clk pulses.
REQ-008 SHALL have ports: alarm_hours out 5, alarm_minutes out 6  stored alarm time.
REQ-009 SHALL have port: edit_field  out  1  0 = hours, 1 = minutes.
REQ-010 SHALL have ports: ringing out 1, snoozing out 1, play_sound out 1  level, to audio block.

Function
REQ-011 SHALL implement FSM states IDLE, ARMED, RINGING, SNOOZE; ringing=1 only in RINGING, snoozing=1 only in SNOOZE.
REQ-012 IDLE -> ARMED on the clk after alarm_en=1 with alarm_set=0; any state -> IDLE on the clk after alarm_en=0.
REQ-013 ARMED -> RINGING on tick_1hz when cur_hours==alarm_hours, cur_minutes==alarm_minutes, cur_seconds==0, alarm_set=0; ringing rises one clk after that tick.
REQ-014 RINGING: 6-bit ring counter cleared on entry, incremented per tick_1hz; at count 59 plus tick -> ARMED (60 s auto-timeout).
REQ-015 RINGING + key_stop -> ARMED next clk; key_stop and key_snooze same clk: stop wins.
REQ-016 RINGING + key_snooze -> SNOOZE; 9-bit snooze counter cleared, incremented per tick_1hz; at 299 plus tick -> RINGING (ring counter cleared); SNOOZE + key_stop -> ARMED.
REQ-017 play_sound SHALL equal 1 in RINGING when ring counter bit0=0 (1 s on / 1 s off), else 0; registered.
REQ-018 alarm_set=1: RINGING/SNOOZE -> ARMED (or IDLE if alarm_en=0) next clk; no match detection while alarm_set=1.
REQ-019 Edit (alarm_set=1 only): key_next toggles edit_field; key_inc/key_dec modify selected field by ±1.
REQ-020 Wrap: hours 23+1->0, 0-1->23; minutes 59+1->0, 0-1->59; key_inc and key_dec same clk: no change.
REQ-021 Keys other than key_stop/key_snooze SHALL be ignored when alarm_set=0; key_stop/key_snooze ignored outside RINGING/SNOOZE.
REQ-022 Editing SHALL NOT alter FSM state except per REQ-018.

Reset
REQ-023 rst=1 SHALL immediately force: state IDLE, alarm_hours=7, alarm_minutes=0, edit_field=0, ring and snooze counters 0, ringing=0, snoozing=0, play_sound=0.
REQ-024 Reset mid-RINGING/SNOOZE SHALL drop play_sound without waiting for clk; after release FSM follows REQ-012.

Configuration
REQ-025 Macro ALARM_SNOOZE_EN defined: snooze per REQ-016, SNOOZE state and counter present.
REQ-026 Macro ALARM_SNOOZE_EN undefined: key_snooze ignored, SNOOZE unreachable, snooze counter removed, snoozing tied 0; all else unchanged.

Verification
REQ-027 Reset, alarm_en=1, time 06:59:59 then tick to 07:00:00 -> ringing=1 one clk after tick, play_sound=1.
REQ-028 Ringing, 60 ticks no keys -> ARMED, ringing=0, play_sound toggled each tick (30 on-seconds).
REQ-029 Ringing, key_stop+key_snooze same clk -> ARMED; repeat with key_snooze alone -> snoozing=1, 300 ticks later ringing=1 (ALARM_SNOOZE_EN defined); undefined -> snooze ignored.
REQ-030 alarm_set=1, edit_field=0, alarm_hours=23, key_inc -> 0; key_next, alarm_minutes=0, key_dec -> 59; key_inc+key_dec same clk -> unchanged.
REQ-031 Ringing, alarm_en dropped -> IDLE next clk; alarm_set raised while ringing -> ARMED; matching tick with alarm_set=1 -> no ring.
REQ-032 rst asserted asynchronously mid-ring -> play_sound=0, alarm 07:00, IDLE before next clk edge.
